pmod_dac_tx: RTL and testbench

Serial transmitter that takes 8-bit processed samples from the reconstruction datapath and drives them out of the FPGA on a Pmod port to an external 12-bit SPI-style DAC (DAC121S101-class). It is the output-side counterpart of the 8-bit Pmod sensor sampling stage. It buffers samples in a small FIFO behind a valid/ready handshake and emits one 16-bit frame per sample with a programmable serial clock rate.

---
 rtl/pmod_dac_tx.sv | 135 +++++++++++++
 tb/tb_pmod_dac_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_dac_tx.sv
// Pmod DAC transmitter: buffers 8-bit samples in a small FIFO and shifts each one
// out as a 16-bit SPI frame (4 mode bits, sample left-justified in 12 bits, 4 pad bits).
module pmod_dac_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       sync_n,
  output logic       sclk,
  output logic       sdata,
  output logic       busy,
  output logic       frame_done
);

  localparam int          AW     = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  DIV_TC = 8'(CLK_DIV - 1);
  localparam logic [8:0]  GAP_TC = 9'(2 * CLK_DIV - 1);
  localparam logic [AW:0] FULL   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  state_t        r_state;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_div;
  logic [4:0]    r_bit_cnt;
  logic [8:0]    r_gap;
  logic [15:0]   r_shift;
  logic          r_sync_n;
  logic          r_sclk;
  logic          r_frame_done;
  logic          r_busy;

  logic          w_push;
  logic          w_pop;
  logic [15:0]   w_frame;

  assign data_ready = (r_count != FULL);
  assign w_push     = data_valid && data_ready;
  assign w_pop      = (r_state == S_LOAD) && (r_count != '0);
  assign w_frame    = {4'b0000, r_mem[r_rd_ptr], 4'b0000};

  // sdata is the shifter MSB; clearing the shifter parks the line low between frames
  assign sdata      = r_shift[15];
  assign sync_n     = r_sync_n;
  assign sclk       = r_sclk;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_div        <= '0;
      r_bit_cnt    <= '0;
      r_gap        <= '0;
      r_shift      <= '0;
      r_sync_n     <= 1'b1;
      r_sclk       <= 1'b1;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_busy       <= (r_state != S_IDLE) || (r_count != '0);
      case (r_state)
        S_IDLE: begin
          r_sync_n <= 1'b1;
          r_sclk   <= 1'b1;
          if (r_count != '0) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_shift   <= w_frame;
          r_div     <= '0;
          r_bit_cnt <= '0;
          r_sync_n  <= 1'b0;
          r_sclk    <= 1'b1;
          r_state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_div == DIV_TC) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            // data moves only on the rising edge so it is stable around the DAC's falling-edge sample
            if (!r_sclk) begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt < 5'd15) begin
                r_shift <= {r_shift[14:0], 1'b0};
              end else begin
                r_shift      <= '0;
                r_sync_n     <= 1'b1;
                r_sclk       <= 1'b1;
                r_frame_done <= 1'b1;
                r_gap        <= '0;
                r_state      <= S_GAP;
              end
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        S_GAP: begin
          if (r_gap == GAP_TC) r_state <= S_IDLE;
          else                 r_gap   <= r_gap + 9'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmod_dac_tx.sv
// Self-checking bench for pmod_dac_tx: random/directed sample streams compared against
// a queue-based model of the expected frames and frame timing.
module tb_pmod_dac_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din, din2;
  logic       dv, dv2;
  logic       dr, sync_n, sclk, sdata, busy, fdone;
  logic       dr2, sync2, sclk2, sdata2, busy2, fdone2;

  initial forever #5 clk = ~clk;

  pmod_dac_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .data_in(din), .data_valid(dv), .data_ready(dr),
    .sync_n(sync_n), .sclk(sclk), .sdata(sdata), .busy(busy), .frame_done(fdone));

  pmod_dac_tx #(.CLK_DIV(2), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .reset(reset), .data_in(din2), .data_valid(dv2), .data_ready(dr2),
    .sync_n(sync2), .sclk(sclk2), .sdata(sdata2), .busy(busy2), .frame_done(fdone2));

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int cur();
    return int'($time / 10);
  endfunction

  // Frame monitor for the CLK_DIV=4 instance, sampled on falling clk edges
  logic [15:0] q_fr[$];
  int          q_low[$], q_nb[$], q_gap[$], q_start[$];
  logic        q_fdr[$];
  int          n_fd = 0, fd_cyc = 0;
  bit          have_rise = 0;

  initial begin
    logic p_sync, p_sclk;
    logic [15:0] fr;
    int nb, t_fall, t_rise;
    p_sync = 1'b1; p_sclk = 1'b1; fr = '0; nb = 0; t_fall = 0; t_rise = 0;
    forever begin
      @(negedge clk);
      if (fdone === 1'b1) begin n_fd++; fd_cyc = cur(); end
      if (reset) begin
        p_sync = 1'b1; p_sclk = 1'b1; have_rise = 0;
      end else begin
        if (p_sync && !sync_n) begin
          if (have_rise) q_gap.push_back(cur() - t_rise);
          t_fall = cur(); fr = '0; nb = 0;
          q_start.push_back(cur());
        end
        if (!sync_n && p_sclk && !sclk) begin fr = {fr[14:0], sdata}; nb++; end
        if (!p_sync && sync_n) begin
          q_fr.push_back(fr); q_low.push_back(cur() - t_fall); q_nb.push_back(nb);
          q_fdr.push_back(fdone);
          t_rise = cur(); have_rise = 1;
        end
        p_sync = sync_n; p_sclk = sclk;
      end
    end
  end

  logic [7:0] exp_q[$];
  int         acc_cyc;

  task automatic clear_mon();
    q_fr.delete(); q_low.delete(); q_nb.delete(); q_gap.delete(); q_start.delete();
    q_fdr.delete(); exp_q.delete(); have_rise = 0;
  endtask

  task automatic send(input logic [7:0] v);
    int k;
    din = v; dv = 1'b1; k = 0;
    while (!dr && k < 3000) begin @(negedge clk); k++; end
    if (!dr) check("send_timeout", 0, 1);
    else begin exp_q.push_back(v); acc_cyc = cur() + 1; end
    @(negedge clk);
    dv = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int lim);
    int k;
    k = 0;
    while (q_fr.size() < n && k < lim) begin @(negedge clk); k++; end
    if (q_fr.size() < n) check("frame_timeout", q_fr.size(), n);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || !sync_n) && k < 5000) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cur() < c) @(negedge clk);
  endtask

  // Each accepted sample must appear as {0000, sample, 0000}, 16 bits, 32*CLK_DIV low
  task automatic compare_frames(input string tag);
    logic [7:0] s;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      if (q_fr.size() == 0) check({tag, "_missing"}, 0, {8'h0, s});
      else begin
        check({tag, "_frame"}, q_fr.pop_front(), {16'h0, 4'h0, s, 4'h0});
        check({tag, "_low"},   q_low.pop_front(), 128);
        check({tag, "_bits"},  q_nb.pop_front(), 16);
        check({tag, "_fdone"}, q_fdr.pop_front(), 1);
      end
    end
    check({tag, "_extra"}, q_fr.size(), 0);
  endtask

  initial begin
    int fd_base, acc, lng, k, t0, low2, nb2, f1, f2;
    logic [7:0] val;
    logic prev_dr, p_s2, deasserted;
    logic [15:0] fr2;

    reset = 1'b1; dv = 1'b0; din = '0; dv2 = 1'b0; din2 = '0;
    repeat (3) @(negedge clk);
    check("rst_sync_n", sync_n, 1);
    check("rst_sclk", sclk, 1);
    check("rst_sdata", sdata, 0);
    check("rst_fdone", fdone, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", dr, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single sample
    clear_mon(); fd_base = n_fd;
    send(8'hA5);
    wait_frames(1, 400);
    if (q_start.size() > 0) check("latency", q_start[0] - acc_cyc, 2);
    else check("latency_nostart", 0, 1);
    compare_frames("single");
    check("single_fd_count", n_fd - fd_base, 1);
    wait_until(fd_cyc + 7);
    check("busy_in_gap", busy, 1);
    wait_until(fd_cyc + 10);
    check("busy_after", busy, 0);

    // back-to-back
    wait_idle(); clear_mon();
    send(8'h00); send(8'hFF); send(8'h3C);
    wait_frames(3, 1000);
    if (q_start.size() >= 3 && q_gap.size() >= 2) begin
      check("b2b_period0", q_start[1] - q_start[0], 138);
      check("b2b_period1", q_start[2] - q_start[1], 138);
      check("b2b_gap0", q_gap[0], 10);
      check("b2b_gap1", q_gap[1], 10);
    end else check("b2b_starts", q_start.size(), 3);
    compare_frames("b2b");

    // backpressure: hold valid with incrementing data
    wait_idle(); clear_mon();
    val = 8'h01; acc = 0; lng = 0; deasserted = 0; prev_dr = 1'b0; k = 0;
    dv = 1'b1;
    while (acc < 12 && k < 3000) begin
      din = val;
      if (!dr && !deasserted) begin deasserted = 1; check("bp_first_burst", acc, 5); end
      if (deasserted && dr && prev_dr) lng++;
      prev_dr = dr;
      if (dr) begin exp_q.push_back(val); val++; acc++; end
      @(negedge clk); k++;
    end
    dv = 1'b0;
    check("bp_deasserted", deasserted, 1);
    check("bp_single_reaccept", lng, 0);
    wait_frames(12, 3000);
    compare_frames("bp");

    // FIFO wrap with random valid gaps
    wait_idle(); clear_mon();
    for (int i = 0; i < 20; i++) begin
      send(8'(8'h10 + i));
      repeat ($urandom_range(0, 3)) begin din = 8'($urandom); @(negedge clk); end
    end
    wait_frames(20, 4000);
    compare_frames("wrap");

    // reset in the middle of a frame with two samples queued
    wait_idle(); clear_mon();
    send(8'h77); send(8'h55); send(8'h66);
    k = 0;
    while (sync_n && k < 100) begin @(negedge clk); k++; end
    repeat (34) @(negedge clk);
    check("mid_sync_low", sync_n, 0);
    fd_base = n_fd;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_sync_n", sync_n, 1);
    check("mid_rst_sclk", sclk, 1);
    check("mid_rst_ready", dr, 1);
    clear_mon();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (400) @(negedge clk);
    check("post_rst_no_frames", q_start.size(), 0);
    check("post_rst_no_fdone", n_fd - fd_base, 0);
    check("post_rst_busy", busy, 0);
    send(8'h42);
    wait_frames(1, 400);
    compare_frames("post_rst");

    // CLK_DIV=2 instance
    din2 = 8'h81; dv2 = 1'b1;
    @(negedge clk);
    dv2 = 1'b0;
    k = 0;
    while (sync2 && k < 50) begin @(negedge clk); k++; end
    check("div2_started", sync2, 0);
    t0 = cur(); fr2 = '0; nb2 = 0; f1 = 0; f2 = 0; p_s2 = sclk2; k = 0;
    while (!sync2 && k < 500) begin
      @(negedge clk); k++;
      if (!sync2 && p_s2 && !sclk2) begin
        fr2 = {fr2[14:0], sdata2}; nb2++;
        if (nb2 == 1) f1 = cur();
        if (nb2 == 2) f2 = cur();
      end
      p_s2 = sclk2;
    end
    low2 = cur() - t0;
    check("div2_frame", fr2, 16'h0810);
    check("div2_bits", nb2, 16);
    check("div2_low", low2, 64);
    check("div2_sclk_period", f2 - f1, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
